instr_prefetch: RTL and testbench

- Parametrised successor of the single-register instruction fetcher.
- Runs ahead of the decoder: issues program-memory reads over a req/ack handshake and buffers returned words with their addresses in a DEPTH-entry queue.
- Presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump): flushes the queue and restarts fetching at a new address.

---
 rtl/instr_prefetch.sv | 157 +++++++++++++++
 tb/tb_instr_prefetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: runs ahead of decode, fetching program words
// over a single-outstanding req/ack port into a DEPTH-entry queue.
// The head of the queue is presented to decode over valid/ready.
// A redirect flushes the queue and moves the fetch pointer. A read that is
// still in flight at that moment completes, and its data is dropped.
module instr_prefetch #(
  parameter int unsigned               WORD_WIDTH = 32'd16,
  parameter int unsigned               ADDR_WIDTH = 32'd16,
  parameter int unsigned               DEPTH      = 32'd4,
  parameter logic [ADDR_WIDTH-1:0]     RESET_ADDR = '0,
  parameter int unsigned               TRACE      = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 32'd1;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Queue storage: data word and its address per entry.
  logic [WORD_WIDTH-1:0] word_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] fp_q, fp_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  discard_q, discard_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;

  logic                  ack_s;
  logic                  hold_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      remain_s;
  logic                  unused_trace_s;

  // The trace option only affects simulation output; it has no hardware effect.
  assign unused_trace_s = (TRACE != 32'd0);

  // An ack only counts while a request is outstanding; a late ack is ignored.
  assign ack_s  = mem_req_q & mem_ack;
  assign hold_s = mem_req_q & ~mem_ack;
  assign push_s = ack_s & ~discard_q & ~redirect;
  assign pop_s  = instr_valid_q & instr_ready & ~redirect;

  // Next-state for the queue, fetch pointer, request port and the registered head.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fp_d          = fp_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    remain_s      = count_q - {{(CNT_W-1){1'b0}}, pop_s};

    if (redirect) begin
      // Flush everything. A read still in flight is marked for discard.
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      fp_d          = redirect_addr;
      instr_valid_d = 1'b0;
      discard_d     = hold_s;
    end else begin
      count_d   = remain_s + {{(CNT_W-1){1'b0}}, push_s};
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_s);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_s);
      fp_d      = push_s ? (fp_q + ADDR_ONE) : fp_q;
      discard_d = ack_s ? 1'b0 : discard_q;
      instr_valid_d = (count_d != '0);
      // The head after the edge is an older entry if any survive the pop.
      // Otherwise it is the word arriving now.
      if (remain_s != '0) begin
        instr_d    = word_mem_q[rd_ptr_d];
        instr_pc_d = pc_mem_q[rd_ptr_d];
      end else if (push_s) begin
        instr_d    = mem_data;
        instr_pc_d = fp_q;
      end else begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
      end
    end

    // One outstanding read. A request slot is reserved, so a push always fits.
    if (hold_s) begin
      mem_req_d  = 1'b1;
      mem_addr_d = mem_addr_q;
    end else begin
      mem_req_d  = (count_d != DEPTH_C);
      mem_addr_d = fp_d;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fp_q          <= RESET_ADDR;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_ADDR;
      discard_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fp_q          <= fp_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Queue storage write; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push_s) begin
      word_mem_q[wr_ptr_q] <= mem_data;
      pc_mem_q[wr_ptr_q]   <= fp_q;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: a queue-based reference model,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  always #5 clk = ~clk;

  // Main DUT signals
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;

  // Memory behaviour controls
  int          lat = 0;
  logic        mem_en = 1'b1;
  logic        force_ack = 1'b0;
  int          wait_q = 0;

  // Wrap-test DUT signals
  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [15:0] w_data;
  logic [15:0] w_instr;
  logic [15:0] w_pc;
  logic        w_valid;
  logic        w_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  assign mem_ack  = force_ack | (mem_en & mem_req & (wait_q >= lat));
  assign mem_data = mem_addr * 16'd3;
  assign w_ack    = w_req;
  assign w_data   = w_addr * 16'd3;

  instr_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  instr_prefetch #(.RESET_ADDR(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_data(w_data),
    .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_addr(16'h0000)
  );

  // Memory latency counter: cycles the current request has been waiting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= 0;
    else if (mem_req && !mem_ack) wait_q <= wait_q + 1;
    else wait_q <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [15:0] m_fp = 16'h0000;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic        m_req = 1'b0;
  logic        m_disc = 1'b0;
  logic        m_valid = 1'b0;
  logic        ack_m, hold_m;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_fp = 16'h0000; m_addr = 16'h0000; m_req = 1'b0; m_disc = 1'b0;
      m_valid = 1'b0; m_instr = 16'h0000; m_pc = 16'h0000;
    end else begin
      ack_m  = m_req && mem_ack;
      hold_m = m_req && !mem_ack;
      if (mem_req && mem_ack) ack_cnt++;
      if (redirect) begin
        m_q.delete();
        m_valid = 1'b0;
        m_fp    = redirect_addr;
        m_disc  = hold_m;
      end else begin
        if (m_valid && instr_ready) void'(m_q.pop_front());
        if (ack_m) begin
          if (m_disc) m_disc = 1'b0;
          else begin
            m_q.push_back({m_fp, mem_data});
            m_fp = m_fp + 16'd1;
          end
        end
        m_valid = (m_q.size() != 0);
        if (m_valid) begin
          m_pc    = m_q[0][31:16];
          m_instr = m_q[0][15:0];
        end
      end
      if (!hold_m) begin
        m_req  = (m_q.size() < DEPTH);
        m_addr = m_fp;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cyc_mem_req",  {31'd0, mem_req},     {31'd0, m_req});
    check("cyc_mem_addr", {16'd0, mem_addr},    {16'd0, m_addr});
    check("cyc_valid",    {31'd0, instr_valid}, {31'd0, m_valid});
    check("cyc_instr",    {16'd0, instr},       {16'd0, m_instr});
    check("cyc_pc",       {16'd0, instr_pc},    {16'd0, m_pc});
  end

  // ---------------- wrap-around scenario on the second DUT ----------------
  initial begin
    logic [15:0] wpc[4];
    logic [15:0] wins[4];
    logic [15:0] exp_pc[4];
    logic [15:0] exp_in[4];
    int wn;
    exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_in = '{16'hFFFA, 16'hFFFD, 16'h0000, 16'h0003};
    wn = 0;
    @(posedge rst_n);
    for (int c = 0; c < 20 && wn < 4; c++) begin
      @(negedge clk);
      if (w_valid) begin
        wpc[wn] = w_pc; wins[wn] = w_instr; wn++;
      end
    end
    check("t5_count", wn, 4);
    for (int i = 0; i < wn; i++) begin
      check("t5_pc", {16'd0, wpc[i]}, {16'd0, exp_pc[i]});
      check("t5_instr", {16'd0, wins[i]}, {16'd0, exp_in[i]});
    end
    w_done = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] got_pc[16];
  logic [15:0] got_in[16];
  int          got_cyc[16];
  int          got_n;

  // Collect accepted instructions, sampling the current negedge first.
  task automatic collect(input int n, input int bound);
    got_n = 0;
    for (int c = 0; c < bound && got_n < n; c++) begin
      if (instr_valid && instr_ready) begin
        got_pc[got_n] = instr_pc; got_in[got_n] = instr; got_cyc[got_n] = c; got_n++;
      end
      if (got_n < n) @(negedge clk);
    end
    check("collect_count", got_n, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int cyc;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_pc", {16'd0, instr_pc}, 32'd0);
    check("rst_w_addr", {16'd0, w_addr}, 32'h0000FFFE);

    // 1: zero-wait streaming, one instruction per cycle
    rst_n = 1'b1;
    collect(4, 20);
    for (int i = 0; i < got_n; i++) begin
      check("t1_pc", {16'd0, got_pc[i]}, i);
      check("t1_instr", {16'd0, got_in[i]}, i * 3);
      check("t1_gap", got_cyc[i] - got_cyc[0], i);
    end
    repeat (5) @(negedge clk);

    // 2: decoder stalled, queue fills to DEPTH then drains in order
    instr_ready = 1'b0;
    do_reset();
    base = ack_cnt;
    repeat (20) @(negedge clk);
    check("t2_fetched", ack_cnt - base, 4);
    check("t2_req_full", {31'd0, mem_req}, 32'd0);
    check("t2_addr_full", {16'd0, mem_addr}, 32'd4);
    check("t2_head", {16'd0, instr_pc}, 32'd0);
    instr_ready = 1'b1;
    collect(5, 20);
    for (int i = 0; i < got_n; i++) begin
      check("t2_pc", {16'd0, got_pc[i]}, i);
      check("t2_gap", got_cyc[i] - got_cyc[0], i);
    end

    // 3: redirect while a slow read of pc 5 is outstanding
    lat = 3;
    do_reset();
    cyc = 0;
    while (!(mem_req && mem_addr == 16'd5) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("t3_found_pc5", {31'd0, (mem_req && mem_addr == 16'd5)}, 32'd1);
    @(negedge clk);
    redirect = 1'b1; redirect_addr = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    check("t3_hold_addr", {16'd0, mem_addr}, 32'd5);
    check("t3_hold_req", {31'd0, mem_req}, 32'd1);
    check("t3_flushed", {31'd0, instr_valid}, 32'd0);
    cyc = 0;
    while (mem_addr == 16'd5 && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    check("t3_next_addr", {16'd0, mem_addr}, 32'h0100);
    collect(3, 40);
    for (int i = 0; i < got_n; i++) check("t3_pc", {16'd0, got_pc[i]}, 32'h0100 + i);

    // 4: redirect coinciding with ack and pop, queue holding 3 entries
    lat = 0;
    instr_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    check("t4_pre_valid", {31'd0, instr_valid}, 32'd1);
    check("t4_pre_addr", {16'd0, mem_addr}, 32'd3);
    check("t4_pre_ack", {31'd0, mem_ack}, 32'd1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    check("t4_empty", {31'd0, instr_valid}, 32'd0);
    check("t4_req", {31'd0, mem_req}, 32'd1);
    check("t4_addr", {16'd0, mem_addr}, 32'h0200);
    collect(2, 10);
    for (int i = 0; i < got_n; i++) check("t4_pc", {16'd0, got_pc[i]}, 32'h0200 + i);

    // 6: asynchronous reset mid-stall, then a late ack
    instr_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_stall_req", {31'd0, mem_req}, 32'd1);
    check("t6_stall_valid", {31'd0, instr_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, mem_req}, 32'd0);
    check("t6_async_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_async_addr", {16'd0, mem_addr}, 32'd0);
    force_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_restart_req", {31'd0, mem_req}, 32'd1);
    check("t6_restart_addr", {16'd0, mem_addr}, 32'd0);
    force_ack = 1'b0; mem_en = 1'b1; instr_ready = 1'b1;
    collect(3, 20);
    for (int i = 0; i < got_n; i++) begin
      check("t6_pc", {16'd0, got_pc[i]}, i);
      check("t6_instr", {16'd0, got_in[i]}, i * 3);
    end

    cyc = 0;
    while (!w_done && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("t5_done", {31'd0, w_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
